// File: rtl/gain_ctrl_pkg.sv
// Shared constants, repeat-FSM state encoding and the saturating step helper
// used by the gain_ctrl mixer blocks.
package gain_ctrl_pkg;

  localparam logic signed [3:0] GAIN_MAX = 4'sb0111;
  localparam logic signed [3:0] GAIN_MIN = 4'sb1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_t;

  // One gain step in the requested direction, clamped to [GAIN_MIN, GAIN_MAX].
  function automatic logic signed [3:0] gain_step(input logic signed [3:0] g,
                                                   input logic              up);
    if (up) return (g == GAIN_MAX) ? g : g + 4'sd1;
    else    return (g == GAIN_MIN) ? g : g - 4'sd1;
  endfunction

endpackage

// File: rtl/gain_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counter debouncer for one raw button.
// level/rise are the next-state view, so users act on the edge the level flips.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          lvl_q;
  logic [CW-1:0] cnt;
  logic          accept;

  // The DEB_CYCLES-th consecutive mismatching sample flips the level.
  assign accept = (sync2 != lvl_q) && (cnt == CW'(DEB_CYCLES - 1));
  assign level  = accept ? sync2 : lvl_q;
  assign rise   = accept && sync2;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      lvl_q <= level;
      if (sync2 == lvl_q || accept) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gain_ctrl.sv
// gain_ctrl: debounced up/down/select buttons drive per-channel 4-bit mixer gains.
// Auto-repeat (HOLD/RPT) is built only when GAIN_CTRL_AUTOREPEAT_EN is defined.
module gain_ctrl
  import gain_ctrl_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DEB_CYCLES = 16,
  parameter int RPT_DELAY  = 32,
  parameter int RPT_RATE   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_up,
  input  logic                    btn_dn,
  input  logic                    btn_sel,
  output logic [4*NCH-1:0]        gain_flat,
  output logic [$clog2(NCH)-1:0]  sel_ch,
  output logic [3:0]              disp_gain,
  output logic                    step_pulse
);

  localparam int SW = $clog2(NCH);

  logic up_lvl, up_rise, dn_lvl, dn_rise, sel_lvl, sel_rise;
  logic both, press_req, step_req, step_up;
  logic signed [3:0] gain [NCH];
  logic signed [3:0] next_gain;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .btn(btn_up), .level(up_lvl), .rise(up_rise));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk(clk), .rst(rst), .btn(btn_dn), .level(dn_lvl), .rise(dn_rise));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .rst(rst), .btn(btn_sel), .level(sel_lvl), .rise(sel_rise));

  // Both directions held cancel each other; select wins over a coincident step.
  assign both      = up_lvl & dn_lvl;
  assign press_req = (up_rise | dn_rise) & ~both & ~sel_rise;

`ifdef GAIN_CTRL_AUTOREPEAT_EN
  localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  rpt_state_t    state;
  logic          dir_up;
  logic [RW-1:0] rcnt;
  logic          held;
  logic          unused_lvl;

  assign unused_lvl = sel_lvl;
  assign held       = dir_up ? up_lvl : dn_lvl;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    step_req = press_req;
    step_up  = up_rise;
    if (!press_req && !both && !sel_rise && held) begin
      if (state == ST_HOLD && rcnt == RW'(RPT_DELAY - 1)) begin
        step_req = 1'b1;
        step_up  = dir_up;
      end else if (state == ST_RPT && rcnt == RW'(RPT_RATE - 1)) begin
        step_req = 1'b1;
        step_up  = dir_up;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      dir_up <= 1'b0;
      rcnt   <= '0;
    end else if (both) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else if (press_req) begin
      state  <= ST_HOLD;
      dir_up <= up_rise;
      rcnt   <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!held) begin
            state <= ST_IDLE;
            rcnt  <= '0;
          end else if (rcnt == RW'(RPT_DELAY - 1)) begin
            state <= ST_RPT;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        ST_RPT: begin
          if (!held) begin
            state <= ST_IDLE;
            rcnt  <= '0;
          end else if (rcnt == RW'(RPT_RATE - 1)) begin
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{sel_lvl, (RPT_DELAY > 0), (RPT_RATE > 0)};
  assign step_req   = press_req;
  assign step_up    = up_rise;
`endif

  assign next_gain = gain_step(gain[sel_ch], step_up);
  assign disp_gain = gain[sel_ch];

  always_comb begin
    gain_flat = '0;
    for (int k = 0; k < NCH; k++) gain_flat[4*k +: 4] = gain[k];
  end

  // NOTE: the gain array is a handful of flops, not a RAM, so it is reset
  // explicitly; every channel must read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) gain[k] <= '0;
      sel_ch     <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (sel_rise) begin
        sel_ch     <= (sel_ch == SW'(NCH - 1)) ? '0 : sel_ch + 1'b1;
        step_pulse <= 1'b1;
      end else if (step_req && next_gain != gain[sel_ch]) begin
        gain[sel_ch] <= next_gain;
        step_pulse   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gain_ctrl.sv
// Self-checking bench for gain_ctrl: table of button presses plus hand-written
// hold/bounce/reset sequences; step pulses are matched against a scoreboard.
module tb_gain_ctrl;

  localparam int LAT   = 18;  // raw press to gain update: 2 sync + 16 debounce
  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_SEL = 2;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] disp;
  } exp_t;

  typedef struct {
    int         btn;
    logic [1:0] sel;
    logic [3:0] disp;
    bit         pulse;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  btn = 3'b000;
  logic [15:0] gain_flat;
  logic [1:0]  sel_ch;
  logic [3:0]  disp_gain;
  logic        step_pulse;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb_q[$];
  vec_t tbl[16];

  gain_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btn[B_UP]), .btn_dn(btn[B_DN]), .btn_sel(btn[B_SEL]),
    .gain_flat(gain_flat), .sel_ch(sel_ch), .disp_gain(disp_gain),
    .step_pulse(step_pulse));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int c, input logic [1:0] s, input logic [3:0] d);
    exp_t e;
    e.cyc = c; e.sel = s; e.disp = d;
    sb_q.push_back(e);
  endtask

  // Every observed pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && step_pulse) begin
      check("pulse_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_sel", {30'd0, sel_ch}, {30'd0, e.sel});
        check("pulse_disp", {28'd0, disp_gain}, {28'd0, e.disp});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_gain_flat", {16'd0, gain_flat}, 32'd0);
    check("rst_sel_ch", {30'd0, sel_ch}, 32'd0);
    check("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int b, input bit pulse, input logic [1:0] s, input logic [3:0] d);
    btn[b] = 1'b1;
    if (pulse) expect_pulse(cyc + LAT, s, d);
    tick(24);
    btn[b] = 1'b0;
    tick(24);
  endtask

  initial begin
    int rel;

    tbl[0]  = '{B_DN,  2'd0, 4'hF, 1'b1};
    tbl[1]  = '{B_DN,  2'd0, 4'hE, 1'b1};
    tbl[2]  = '{B_DN,  2'd0, 4'hD, 1'b1};
    tbl[3]  = '{B_DN,  2'd0, 4'hC, 1'b1};
    tbl[4]  = '{B_DN,  2'd0, 4'hB, 1'b1};
    tbl[5]  = '{B_DN,  2'd0, 4'hA, 1'b1};
    tbl[6]  = '{B_DN,  2'd0, 4'h9, 1'b1};
    tbl[7]  = '{B_DN,  2'd0, 4'h8, 1'b1};
    tbl[8]  = '{B_DN,  2'd0, 4'h8, 1'b0};
    tbl[9]  = '{B_SEL, 2'd1, 4'h0, 1'b1};
    tbl[10] = '{B_UP,  2'd1, 4'h1, 1'b1};
    tbl[11] = '{B_SEL, 2'd2, 4'h0, 1'b1};
    tbl[12] = '{B_DN,  2'd2, 4'hF, 1'b1};
    tbl[13] = '{B_SEL, 2'd3, 4'h0, 1'b1};
    tbl[14] = '{B_SEL, 2'd0, 4'h8, 1'b1};
    tbl[15] = '{B_SEL, 2'd1, 4'h1, 1'b1};

    tick(2);
    do_reset();

    // Up held 100 cycles on ch0.
    btn[B_UP] = 1'b1;
    rel = cyc + LAT;
    expect_pulse(rel, 2'd0, 4'h1);
`ifdef GAIN_CTRL_AUTOREPEAT_EN
    for (int i = 0; i < 6; i++) expect_pulse(rel + 32 + 8 * i, 2'd0, 4'(2 + i));
`endif
    tick(100);
    btn[B_UP] = 1'b0;
    tick(40);
    check("hold_sb_drained", sb_q.size(), 32'd0);
`ifdef GAIN_CTRL_AUTOREPEAT_EN
    check("hold_gain", {16'd0, gain_flat}, 32'h0007);
`else
    check("hold_gain", {16'd0, gain_flat}, 32'h0001);
`endif

    // Reset while up is held (in RPT when auto-repeat is built).
    btn[B_UP] = 1'b1;
`ifndef GAIN_CTRL_AUTOREPEAT_EN
    expect_pulse(cyc + LAT, 2'd0, 4'h2);
`endif
    tick(60);
    check("pre_rst_sb_drained", sb_q.size(), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_held_gain_flat", {16'd0, gain_flat}, 32'd0);
    check("rst_held_pulse", {31'd0, step_pulse}, 32'd0);
    tick(2);
    rst = 1'b0;
    expect_pulse(cyc + LAT, 2'd0, 4'h1);
    tick(25);
    btn[B_UP] = 1'b0;
    tick(30);
    check("rst_held_sb_drained", sb_q.size(), 32'd0);
    check("rst_held_gain", {16'd0, gain_flat}, 32'h0001);

    do_reset();

    // Table: nine downs to saturation, then select walk with some steps.
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].btn, tbl[i].pulse, tbl[i].sel, tbl[i].disp);
      check($sformatf("tbl%0d_sel", i), {30'd0, sel_ch}, {30'd0, tbl[i].sel});
      check($sformatf("tbl%0d_disp", i), {28'd0, disp_gain}, {28'd0, tbl[i].disp});
    end
    check("tbl_sb_drained", sb_q.size(), 32'd0);
    check("tbl_gain_flat", {16'd0, gain_flat}, 32'h0F18);

    // Bouncing up: 10-cycle pulses with 3-cycle gaps, then steady.
    for (int i = 0; i < 3; i++) begin
      btn[B_UP] = 1'b1;
      tick(10);
      btn[B_UP] = 1'b0;
      tick(3);
    end
    btn[B_UP] = 1'b1;
    expect_pulse(cyc + LAT, 2'd1, 4'h2);
    tick(30);
    btn[B_UP] = 1'b0;
    tick(30);
    check("bounce_sb_drained", sb_q.size(), 32'd0);
    check("bounce_disp", {28'd0, disp_gain}, 32'h2);

    // Up and down together: ignored.
    btn[B_UP] = 1'b1;
    btn[B_DN] = 1'b1;
    tick(40);
    btn[B_UP] = 1'b0;
    btn[B_DN] = 1'b0;
    tick(30);
    check("both_gain_flat", {16'd0, gain_flat}, 32'h0F28);
    check("both_sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
